tdc_decoder: RTL and testbench
==============================

TDC_DECODER -- requirements
Module: tdc_decoder

Interface
REQ-001 SHALL have parameter TDC_W, default 64, meaning number of delay-line taps (even, 8..128).
REQ-002 SHALL have parameter CODE_W, default 7, meaning output code width, equal to ceil(log2(TDC_W))+1.
REQ-003 SHALL have parameter CAL_LOG, default 8, meaning the calibration window is 2^CAL_LOG samples.
REQ-004 SHALL have port clk  input  1  meaning the single reference clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port tdc_raw  input  TDC_W  meaning delay-line taps already sampled in the clk domain; bit 0 is nearest the launch point.
REQ-007 SHALL have port sample_en  input  1  meaning tdc_raw is valid this cycle.
REQ-008 SHALL have port cal_start  input  1  meaning a one-cycle pulse that starts a calibration window.
REQ-009 SHALL have port code  output  CODE_W  meaning decoded edge position.
REQ-010 SHALL have port code_valid  output  1  meaning code, ovf and unf are valid this cycle.
REQ-011 SHALL have port ovf  output  1  meaning no edge was found and all taps read 1.
REQ-012 SHALL have port unf  output  1  meaning no edge was found and all taps read 0.
REQ-013 SHALL have port cal_period  output  CODE_W  meaning the maximum code seen in the last completed calibration window.
REQ-014 SHALL have port cal_done  output  1  meaning a one-cycle pulse when cal_period updates.

Function
REQ-015 Stage 1 SHALL register tdc_raw with every odd tap inverted, which undoes the inverting NAND delay stages.
REQ-016 Stage 2 SHALL apply bubble correction: each tap i becomes the 3-input majority of taps i-1, i and i+1. Tap -1 reads 1 and tap TDC_W reads 0.
REQ-017 Stage 3 SHALL set code to the lowest index i at which corrected tap i is 1 and tap i+1 is 0, plus 1. Example: 0x000F on 16 taps gives code 4.
REQ-018 All ones SHALL give code = TDC_W and ovf = 1; all zeros SHALL give code = 0 and unf = 1; ovf and unf SHALL never both be 1.
REQ-019 Latency SHALL be exactly 3 cycles from sample_en high to code_valid high; the pipeline SHALL accept a new sample every cycle.
REQ-020 sample_en SHALL travel as a valid bit through the pipeline; stages that are not valid SHALL hold their data and SHALL NOT assert code_valid.
REQ-021 code, ovf and unf SHALL hold their last value while code_valid is low.
REQ-022 The calibration FSM SHALL have states IDLE, CAL and DONE.
  - IDLE to CAL on cal_start: clears the running maximum and the sample counter.
  - CAL: each code_valid with ovf = 0 and unf = 0 updates the maximum and increments the counter; ovf and unf samples are not counted.
  - CAL to DONE when the counter reaches 2^CAL_LOG.
  - DONE: loads cal_period, pulses cal_done for one cycle, returns to IDLE.
REQ-023 cal_start received in CAL SHALL restart the window; cal_start received in DONE SHALL be ignored.
REQ-024 cal_period SHALL hold its value until the next DONE.
REQ-025 Counter and maximum widths SHALL be sized so that neither wraps within one window.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously clear all pipeline data and valid bits, the FSM (to IDLE), the counter and the maximum.
REQ-027 During reset code = 0, code_valid = 0, ovf = 0, unf = 0, cal_period = 0 and cal_done = 0.
REQ-028 Reset applied mid-pipeline or mid-calibration SHALL discard in-flight samples and the partial window; no code_valid or cal_done SHALL appear after release without a new sample_en or cal_start.
REQ-029 rst_n deassertion SHALL be synchronised to clk by logic outside this block.

Structure
REQ-030 A shared package tdc_pkg SHALL hold the FSM state enumeration and the default TDC_W, CODE_W and CAL_LOG constants.
REQ-031 The priority encoder SHALL be a sub-module named tdc_edge_enc: combinational, parameterised by TDC_W, instantiated in stage 3.

Verification (TDC_W = 16, CAL_LOG = 2)
REQ-032 Raw taps giving 0x000F after polarity normalisation, sample_en for 1 cycle -> code = 4, code_valid high exactly 3 cycles later, ovf = 0, unf = 0.
REQ-033 Normalised 0x00F7 (bubble at bit 3) -> code = 8.
REQ-034 Normalised 0xFFFF -> code = 16 with ovf = 1; normalised 0x0000 -> code = 0 with unf = 1.
REQ-035 sample_en held high for 5 back-to-back cycles with codes 1, 2, 3, 4, 5 -> code_valid high for 5 consecutive cycles carrying the same codes in order.
REQ-036 cal_start, then 4 valid samples with codes 3, 9, 5, 7 and one ovf sample mixed in -> cal_done pulses once, cal_period = 9.
REQ-037 rst_n pulsed low in the cycle after sample_en -> no code_valid follows, all outputs = 0, and the FSM is in IDLE.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants and calibration state encoding for the TDC decoder.
package tdc_pkg;

    localparam int TDC_W_DEF   = 64;
    localparam int CODE_W_DEF  = 7;
    localparam int CAL_LOG_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_DONE = 2'd2
    } cal_state_e;

endpackage

// File: rtl/tdc_edge_enc.sv
// Thermometer edge encoder: code is one above the lowest 1->0 transition,
// with the tap beyond the top of the line reading 0.
module tdc_edge_enc #(
    parameter int TDC_W  = 64,
    parameter int CODE_W = $clog2(TDC_W) + 1
) (
    input  logic [TDC_W-1:0]  therm_i,
    output logic [CODE_W-1:0] code_o,
    output logic              ovf_o,
    output logic              unf_o
);

    logic [TDC_W:0] ext;

    assign ext = {1'b0, therm_i};

    // Scan downwards so the lowest matching edge is the one that sticks.
    always_comb begin
        code_o = '0;
        for (int i = TDC_W - 1; i >= 0; i--) begin
            if (ext[i] && !ext[i+1]) begin
                code_o = CODE_W'(i + 1);
            end
        end
    end

    assign ovf_o = &therm_i;
    assign unf_o = ~|therm_i;

endmodule

// File: rtl/tdc_decoder.sv
// Three-stage delay-line TDC decoder (polarity fix, bubble correction, edge
// encode) with a max-code calibration window.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for cal_start; cal_period holds the last result
// CAL     | collecting in-range codes, tracking the maximum
// DONE    | window complete; loads cal_period and pulses cal_done
module tdc_decoder
    import tdc_pkg::*;
#(
    parameter int TDC_W   = TDC_W_DEF,
    parameter int CODE_W  = CODE_W_DEF,
    parameter int CAL_LOG = CAL_LOG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TDC_W-1:0]  tdc_raw,
    input  logic              sample_en,
    input  logic              cal_start,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              ovf,
    output logic              unf,
    output logic [CODE_W-1:0] cal_period,
    output logic              cal_done
);

    localparam int CNT_W = CAL_LOG + 1;
    localparam logic [TDC_W-1:0] ODD_MASK = {(TDC_W / 2){2'b10}};
    localparam logic [CNT_W-1:0] CAL_LAST = {1'b0, {CAL_LOG{1'b1}}};

    logic [TDC_W-1:0]   norm_d, norm_q;
    logic               v1_q;
    logic [TDC_W+1:0]   norm_ext;
    logic [TDC_W-1:0]   bub_d, bub_q;
    logic               v2_q;
    logic [CODE_W-1:0]  code_d, code_q;
    logic               ovf_d, ovf_q, unf_d, unf_q;
    logic               code_valid_q;

    cal_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CODE_W-1:0]  max_q;
    logic [CODE_W-1:0]  cal_period_q;
    logic               cal_done_q;

    assign norm_d = tdc_raw ^ ODD_MASK;

    // Virtual tap -1 reads 1 and tap TDC_W reads 0.
    assign norm_ext = {1'b0, norm_q, 1'b1};
    assign bub_d = (norm_ext[TDC_W-1:0] & norm_ext[TDC_W:1])
                 | (norm_ext[TDC_W-1:0] & norm_ext[TDC_W+1:2])
                 | (norm_ext[TDC_W:1]   & norm_ext[TDC_W+1:2]);

    tdc_edge_enc #(
        .TDC_W  (TDC_W),
        .CODE_W (CODE_W)
    ) u_edge_enc (
        .therm_i (bub_q),
        .code_o  (code_d),
        .ovf_o   (ovf_d),
        .unf_o   (unf_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_q       <= '0;
            v1_q         <= 1'b0;
            bub_q        <= '0;
            v2_q         <= 1'b0;
            code_q       <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            code_valid_q <= 1'b0;
        end else begin
            v1_q         <= sample_en;
            v2_q         <= v1_q;
            code_valid_q <= v2_q;
            if (sample_en) begin
                norm_q <= norm_d;
            end
            if (v1_q) begin
                bub_q <= bub_d;
            end
            if (v2_q) begin
                code_q <= code_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            max_q        <= '0;
            cal_period_q <= '0;
            cal_done_q   <= 1'b0;
        end else begin
            cal_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cal_start) begin
                        state_q <= ST_CAL;
                        cnt_q   <= '0;
                        max_q   <= '0;
                    end
                end
                ST_CAL: begin
                    if (cal_start) begin
                        cnt_q <= '0;
                        max_q <= '0;
                    end else if (code_valid_q && !ovf_q && !unf_q) begin
                        if (code_q > max_q) begin
                            max_q <= code_q;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CAL_LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    cal_period_q <= max_q;
                    cal_done_q   <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
    assign cal_period = cal_period_q;
    assign cal_done   = cal_done_q;

endmodule

// File: tb/tb_tdc_decoder.sv
// Bench for tdc_decoder at 16 taps with a 4-sample calibration window.
module tb_tdc_decoder;
    import tdc_pkg::*;

    localparam int TW = 16;
    localparam int CW = 5;
    localparam int CL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] tdc_raw = '0;
    logic          sample_en = 1'b0;
    logic          cal_start = 1'b0;
    logic [CW-1:0] code;
    logic          code_valid;
    logic          ovf;
    logic          unf;
    logic [CW-1:0] cal_period;
    logic          cal_done;

    tdc_decoder #(.TDC_W(TW), .CODE_W(CW), .CAL_LOG(CL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tdc_raw    (tdc_raw),
        .sample_en  (sample_en),
        .cal_start  (cal_start),
        .code       (code),
        .code_valid (code_valid),
        .ovf        (ovf),
        .unf        (unf),
        .cal_period (cal_period),
        .cal_done   (cal_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] norm;
        int          code;
        bit          o;
        bit          u;
    } vec_t;

    typedef struct {
        int due;
        int code;
        bit o;
        bit u;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] to_raw(logic [15:0] norm);
        logic [15:0] odd;
        odd = 16'hAAAA;
        return norm ^ odd;
    endfunction

    function automatic logic [15:0] therm(int k);
        logic [31:0] t;
        t = (32'h1 << k) - 32'h1;
        return t[15:0];
    endfunction

    // Reference: majority vote per tap, then first 1->0 edge from the bottom.
    function automatic void ref_decode(input logic [15:0] norm, output int c,
                                       output bit o, output bit u);
        int tap[-1:16];
        int corr[0:16];
        int ones;
        tap[-1] = 1;
        tap[16] = 0;
        for (int i = 0; i < 16; i++) tap[i] = int'(norm[i]);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            corr[i] = ((tap[i-1] + tap[i] + tap[i+1]) >= 2) ? 1 : 0;
            ones += corr[i];
        end
        corr[16] = 0;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            if (corr[i] == 1 && corr[i+1] == 0) begin
                c = i + 1;
                break;
            end
        end
        o = (ones == 16);
        u = (ones == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cal_done) done_cnt++;
    endtask

    task automatic feed(logic [15:0] norm);
        sample_en = 1'b1;
        tdc_raw   = to_raw(norm);
        tick();
        sample_en = 1'b0;
    endtask

    task automatic pulse_cal();
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
    endtask

    vec_t tbl[10];
    exp_t q[$];
    int   got_code[$];
    int   got_idx[$];

    initial begin
        int   rc, cnt_m, max_m, exp_last;
        bit   ro, ru;
        logic [15:0] norm;
        exp_t e;

        tbl[0] = '{16'h000F, 4,  1'b0, 1'b0};
        tbl[1] = '{16'h00F7, 8,  1'b0, 1'b0};
        tbl[2] = '{16'hFFFF, 16, 1'b1, 1'b0};
        tbl[3] = '{16'h0000, 0,  1'b0, 1'b1};
        tbl[4] = '{16'h0001, 1,  1'b0, 1'b0};
        tbl[5] = '{16'h0002, 1,  1'b0, 1'b0};
        tbl[6] = '{16'h7FFF, 15, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 0,  1'b0, 1'b1};
        tbl[8] = '{16'hFFFE, 16, 1'b1, 1'b0};
        tbl[9] = '{16'h0F0F, 4,  1'b0, 1'b0};

        #2;
        chk("rst_code", int'(code), 0);
        chk("rst_valid", int'(code_valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_unf", int'(unf), 0);
        chk("rst_cal_period", int'(cal_period), 0);
        chk("rst_cal_done", int'(cal_done), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single samples: valid exactly 3 cycles later, then held.
        foreach (tbl[n]) begin
            feed(tbl[n].norm);
            chk("lat_c1_valid", int'(code_valid), 0);
            tick();
            chk("lat_c2_valid", int'(code_valid), 0);
            tick();
            chk("lat_c3_valid", int'(code_valid), 1);
            chk("vec_code", int'(code), tbl[n].code);
            chk("vec_ovf", int'(ovf), int'(tbl[n].o));
            chk("vec_unf", int'(unf), int'(tbl[n].u));
            tick();
            chk("hold_valid", int'(code_valid), 0);
            chk("hold_code", int'(code), tbl[n].code);
        end

        // Back-to-back stream of codes 1..5.
        for (int k = 1; k <= 10; k++) begin
            if (k <= 5) begin
                sample_en = 1'b1;
                tdc_raw   = to_raw(therm(k));
            end else begin
                sample_en = 1'b0;
            end
            tick();
            if (code_valid) begin
                got_code.push_back(int'(code));
                got_idx.push_back(k);
            end
        end
        chk("b2b_count", got_code.size(), 5);
        foreach (got_code[i]) begin
            chk("b2b_code", got_code[i], i + 1);
            chk("b2b_cycle", got_idx[i], i + 3);
        end

        // Calibration: codes 3, 9, ovf, 5, 7.
        done_cnt = 0;
        pulse_cal();
        feed(therm(3));
        feed(therm(9));
        feed(16'hFFFF);
        feed(therm(5));
        feed(therm(7));
        for (int k = 0; k < 12; k++) tick();
        chk("cal_done_pulses", done_cnt, 1);
        chk("cal_period", int'(cal_period), 9);

        // Restart in CAL discards the partial window.
        done_cnt = 0;
        pulse_cal();
        feed(therm(12));
        feed(therm(13));
        for (int k = 0; k < 5; k++) tick();
        chk("restart_no_done", done_cnt, 0);
        pulse_cal();
        for (int k = 2; k <= 5; k++) feed(therm(k));
        for (int k = 0; k < 12; k++) tick();
        chk("restart_done_pulses", done_cnt, 1);
        chk("restart_period", int'(cal_period), 5);

        // Random stream under a calibration window, checked against the model.
        done_cnt = 0;
        cnt_m = 0;
        max_m = 0;
        exp_last = -1;
        pulse_cal();
        for (int n = 0; n < 260; n++) begin
            if (n < 250 && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    norm = 16'($urandom);
                end else begin
                    norm = therm($urandom_range(0, 16));
                    if ($urandom_range(0, 2) == 0) norm[$urandom_range(0, 15)] ^= 1'b1;
                end
                ref_decode(norm, rc, ro, ru);
                q.push_back('{cyc + 3, rc, ro, ru});
                sample_en = 1'b1;
                tdc_raw   = to_raw(norm);
            end else begin
                sample_en = 1'b0;
                tdc_raw   = 16'($urandom);
            end
            tick();
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rnd_valid", int'(code_valid), 1);
                chk("rnd_code", int'(code), e.code);
                chk("rnd_ovf", int'(ovf), int'(e.o));
                chk("rnd_unf", int'(unf), int'(e.u));
                exp_last = e.code;
                if (!e.o && !e.u && cnt_m < 4) begin
                    cnt_m++;
                    if (e.code > max_m) max_m = e.code;
                end
            end else begin
                chk("rnd_idle_valid", int'(code_valid), 0);
                if (exp_last >= 0) chk("rnd_hold_code", int'(code), exp_last);
            end
        end
        sample_en = 1'b0;
        chk("rnd_queue_drained", q.size(), 0);
        chk("rnd_cal_samples", cnt_m, 4);
        chk("rnd_cal_done_pulses", done_cnt, 1);
        chk("rnd_cal_period", int'(cal_period), max_m);

        // Reset in the cycle after sample_en, with a calibration in progress.
        pulse_cal();
        feed(therm(6));
        feed(therm(4));
        rst_n = 1'b0;
        #2;
        chk("mid_rst_code", int'(code), 0);
        chk("mid_rst_valid", int'(code_valid), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_unf", int'(unf), 0);
        chk("mid_rst_cal_period", int'(cal_period), 0);
        chk("mid_rst_cal_done", int'(cal_done), 0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("post_rst_valid", int'(code_valid), 0);
            chk("post_rst_code", int'(code), 0);
        end
        chk("post_rst_cal_done", done_cnt, 0);
        chk("post_rst_cal_period", int'(cal_period), 0);
        chk("post_rst_state", int'(dut.state_q), int'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
